// File: rtl/regfile_32x64.sv
// 32 x DATA_W register file: two combinational read ports and one clocked write port.
// The write enables come from a tree of enabled 2:4 decoders. The ZERO_REG index always reads as zero.

module regfile_dec2to4 (
    input  logic       en,
    input  logic [1:0] a,
    output logic [3:0] y
);
    // With en low the output is forced to zero, so an unknown address cannot raise any enable.
    always_comb begin
        y = 4'b0000;
        if (en) begin
            case (a)
                2'd0:    y = 4'b0001;
                2'd1:    y = 4'b0010;
                2'd2:    y = 4'b0100;
                default: y = 4'b1000;
            endcase
        end
    end
endmodule

module regfile_dec3to8 (
    input  logic       en,
    input  logic [2:0] a,
    output logic [7:0] y
);
    logic en_lo;
    logic en_hi;

    assign en_lo = en & ~a[2];
    assign en_hi = en &  a[2];

    regfile_dec2to4 u_lo (.en(en_lo), .a(a[1:0]), .y(y[3:0]));
    regfile_dec2to4 u_hi (.en(en_hi), .a(a[1:0]), .y(y[7:4]));
endmodule

module regfile_32x64 #(
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              RegWrite,
    input  logic [4:0]        WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [4:0]        ReadRegister1,
    input  logic [4:0]        ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);
    localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

    logic [3:0]        grp_en;
    logic [31:0]       reg_en;
    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] regs_d [32];

    regfile_dec2to4 u_dec_top (
        .en (RegWrite),
        .a  (WriteRegister[4:3]),
        .y  (grp_en)
    );

    for (genvar g = 0; g < 4; g++) begin : g_dec
        regfile_dec3to8 u_dec_grp (
            .en (grp_en[g]),
            .a  (WriteRegister[2:0]),
            .y  (reg_en[g*8 +: 8])
        );
    end

    // The zero register never loads, so its flops stay at their reset value.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
            if (reg_en[i] && (i != ZERO_REG)) begin
                regs_d[i] = WriteData;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        ReadData1 = (ReadRegister1 == ZERO_IDX) ? '0 : regs_q[ReadRegister1];
        ReadData2 = (ReadRegister2 == ZERO_IDX) ? '0 : regs_q[ReadRegister2];
    end
endmodule

// File: tb/tb_regfile_32x64.sv
// Directed bench for regfile_32x64. A reference array drives an expected-value queue,
// and every read is checked against the front of that queue.

module tb_regfile_32x64;
    localparam int W = 64;

    logic         clk;
    logic         reset_n;
    logic         RegWrite;
    logic [4:0]   WriteRegister;
    logic [W-1:0] WriteData;
    logic [4:0]   ReadRegister1;
    logic [4:0]   ReadRegister2;
    logic [W-1:0] ReadData1;
    logic [W-1:0] ReadData2;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model [32];
    int           n_cmp;
    int           n_err;

    regfile_32x64 dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs);
        logic [W-1:0] exp;
        exp = exp_q.pop_front();
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_pair(input int a1, input int a2, input string tag);
        @(negedge clk);
        ReadRegister1 = 5'(a1);
        ReadRegister2 = 5'(a2);
        exp_q.push_back(model[a1]);
        exp_q.push_back(model[a2]);
        #1;
        chk($sformatf("%s_p1[%0d]", tag, a1), ReadData1);
        chk($sformatf("%s_p2[%0d]", tag, a2), ReadData2);
    endtask

    task automatic write_reg(input int idx, input logic [W-1:0] data);
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = 5'(idx);
        WriteData     = data;
        @(posedge clk);
        if (reset_n && idx != 31) model[idx] = data;
        #1;
        RegWrite = 1'b0;
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset_n       = 1'b0;
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        clear_model();

        // Reads during reset, and a write attempted while reset is held.
        for (int i = 0; i < 32; i++) read_pair(i, 31 - i, "rst_read");
        write_reg(3, 64'h1234_5678_9ABC_DEF0);
        read_pair(3, 3, "rst_wr_ignored");

        // Releasing reset with a write on the first edge: that write must land.
        @(negedge clk);
        reset_n       = 1'b1;
        RegWrite      = 1'b1;
        WriteRegister = 5'd0;
        WriteData     = 64'h100;
        @(posedge clk);
        model[0] = 64'h100;
        #1;
        RegWrite = 1'b0;
        read_pair(0, 0, "release_wr");

        for (int i = 1; i < 31; i++) write_reg(i, 64'h100 + 64'(i));
        for (int i = 0; i < 32; i++) read_pair(i, 31 - i, "fill");

        // Write enable low: nothing may change, even with an unknown address.
        @(negedge clk);
        RegWrite      = 1'b0;
        WriteRegister = 5'd5;
        WriteData     = '1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        WriteRegister = 'x;
        repeat (2) @(posedge clk);
        WriteRegister = 5'd0;
        read_pair(5, 5, "we_low_hold");
        read_pair(0, 30, "we_low_x");

        write_reg(31, 64'hDEAD_BEEF_DEAD_BEEF);
        read_pair(31, 31, "zero_reg");
        for (int i = 0; i < 31; i++) read_pair(i, i, "after_zero_wr");

        // Same-cycle read and write of index 7: old value before the edge, new value after it.
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = 5'd7;
        WriteData     = 64'hA5A5_A5A5_A5A5_A5A5;
        ReadRegister1 = 5'd7;
        exp_q.push_back(model[7]);
        #1;
        chk("rw_before_edge", ReadData1);
        @(posedge clk);
        model[7] = 64'hA5A5_A5A5_A5A5_A5A5;
        #1;
        RegWrite = 1'b0;
        exp_q.push_back(model[7]);
        chk("rw_after_edge", ReadData1);
        read_pair(7, 7, "same_index");

        for (int k = 0; k < 20; k++) begin
            write_reg($urandom_range(0, 31), {$urandom, $urandom});
            read_pair($urandom_range(0, 31), $urandom_range(0, 31), "rand");
        end

        // Reset asserted between edges: reads must drop to zero immediately.
        write_reg(10, 64'h0BAD_F00D_0BAD_F00D);
        @(negedge clk);
        ReadRegister1 = 5'd10;
        ReadRegister2 = 5'd1;
        #2;
        reset_n = 1'b0;
        clear_model();
        exp_q.push_back(model[10]);
        exp_q.push_back(model[1]);
        #1;
        chk("midrst_p1", ReadData1);
        chk("midrst_p2", ReadData2);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) read_pair(i, 31 - i, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_32x64.md
REGFILE_32X64 -- requirements
Module: regfile_32x64

Interface
REQ-001 Parameter: DATA_W, 64, width of each register and of every data port.
REQ-002 Parameter: ZERO_REG, 31, index of the hardwired-zero register.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: RegWrite  input  1  write enable; write occurs only when 1 at a rising clk edge.
REQ-006 Port: WriteRegister  input  5  destination register index.
REQ-007 Port: WriteData  input  DATA_W  data written to the destination register.
REQ-008 Port: ReadRegister1  input  5  read port 1 index.
REQ-009 Port: ReadRegister2  input  5  read port 2 index.
REQ-010 Port: ReadData1  output  DATA_W  contents of register ReadRegister1.
REQ-011 Port: ReadData2  output  DATA_W  contents of register ReadRegister2.

Function
REQ-012 Storage SHALL be 32 registers of DATA_W bits each, held in edge-triggered flops clocked by clk.
REQ-013 Write-address decode SHALL be 5-to-32, built from the team's 2:4 enabled decoder stages: one 2:4 on WriteRegister[4:3] enabled by RegWrite; four 3:8 stages on WriteRegister[2:0], each enabled by one 2:4 output.
REQ-014 Exactly one register enable SHALL be high when RegWrite=1; none SHALL be high when RegWrite=0.
REQ-015 On a rising clk edge with RegWrite=1, register WriteRegister SHALL load WriteData; all other registers SHALL hold.
REQ-016 On a rising clk edge with RegWrite=0, every register SHALL hold.
REQ-017 Register ZERO_REG SHALL always read 0; writes to it SHALL be discarded, with no other register affected.
REQ-018 Read paths SHALL be combinational 32:1 muxes (no clock); ReadDataN SHALL follow ReadRegisterN changes within the same cycle.
REQ-019 Write latency SHALL be one edge: a value written at edge k SHALL appear on a read port addressing it after edge k, not before.
REQ-020 Same-cycle read and write of one index (non-zero): before the edge the read port SHALL show the old value; after the edge, the new value. No internal bypass.
REQ-021 Both read ports SHALL be independent; equal indices SHALL return identical data.
REQ-022 Unknown or X on WriteRegister while RegWrite=0 SHALL NOT corrupt any register.

Reset
REQ-023 reset_n=0 SHALL clear all 32 registers to 0 immediately, independent of clk.
REQ-024 While reset_n=0, writes SHALL be ignored and ReadData1/ReadData2 SHALL be 0 for every index.
REQ-025 Deassertion of reset_n SHALL take effect at the first rising clk edge after release; a write presented on that edge SHALL complete.
REQ-026 Reset asserted mid-sequence SHALL discard all prior contents; no register retains a pre-reset value.

Verification
REQ-027 Reset then read all indices on both ports -> ReadData1=ReadData2=0 for indices 0..31.
REQ-028 Write 0x0000_0000_0000_0100+i to register i for i=0..30, then read all via both ports -> each returns its value; index 31 returns 0.
REQ-029 RegWrite=0, WriteRegister=5, WriteData=0xFFFF_FFFF_FFFF_FFFF for 4 edges -> register 5 keeps prior value 0x105.
REQ-030 RegWrite=1, WriteRegister=31, WriteData=0xDEAD_BEEF_DEAD_BEEF -> ReadData1 at index 31 = 0; registers 0..30 unchanged.
REQ-031 RegWrite=1, WriteRegister=ReadRegister1=7, WriteData=0xA5A5_A5A5_A5A5_A5A5 -> ReadData1 = 0x107 before edge, 0xA5A5_A5A5_A5A5_A5A5 after edge.
REQ-032 Assert reset_n=0 between clk edges after REQ-028 pattern -> ReadData1/ReadData2 drop to 0 without a clk edge; all indices read 0 after release.
